// File: rtl/rd_seq_ctrl_pkg.sv
// Shared definitions for the read sequencer: one-hot state encoding,
// state bit positions and width helpers for the counter and requester index.
package rd_seq_ctrl_pkg;

    localparam int IDLE_BIT = 0;
    localparam int READ_BIT = 1;
    localparam int DLY_BIT  = 2;
    localparam int DONE_BIT = 3;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_READ = 4'b0010,
        ST_DLY  = 4'b0100,
        ST_DONE = 4'b1000
    } state_e;

    // One spare bit so the timeout count can never wrap.
    function automatic int cnt_width(input int tmo);
        return $clog2(tmo) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rd_seq_ctrl_rr_arb.sv
// Combinational round-robin picker: the first set request at or after the
// pointer, wrapping, as both a one-hot vector and a binary index.
module rr_arb
    import rd_seq_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int PW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] pick_o,
    output logic [PW-1:0]   idx_o
);

    logic [PW-1:0] cand_s;

    // Scan from farthest to nearest so the nearest requester wins.
    always_comb begin
        pick_o = '0;
        idx_o  = '0;
        cand_s = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand_s = PW'((int'(ptr_i) + k) % NREQ);
            if (req_i[cand_s]) begin
                pick_o = NREQ'(1) << cand_s;
                idx_o  = cand_s;
            end else begin
                pick_o = pick_o;
                idx_o  = idx_o;
            end
        end
    end

endmodule

// File: rtl/rd_seq_ctrl.sv
// One-hot read sequencer sharing a wait-stated memory read port between
// NREQ requesters with round-robin grant and a wait-state timeout.
module rd_seq_ctrl
    import rd_seq_ctrl_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int AW   = 8,
    parameter int DW   = 8,
    parameter int TMO  = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic                 err,
    output logic [DW-1:0]        rdata,
    output logic                 mem_rd,
    output logic [AW-1:0]        mem_addr,
    input  logic [DW-1:0]        mem_rdata,
    input  logic                 ws,
    output logic [3:0]           state
);

    localparam int PW = idx_width(NREQ);
    localparam int CW = cnt_width(TMO);
    localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);
    localparam logic [PW-1:0] IDX_LAST = PW'(NREQ - 1);

    state_e          state_q;
    logic [NREQ-1:0] gnt_q;
    logic [PW-1:0]   idx_q;
    logic [PW-1:0]   ptr_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic [CW-1:0]   cnt_q;

    logic [NREQ-1:0] pick_s;
    logic [PW-1:0]   pick_idx_s;
    logic [AW-1:0]   addr_sel_s;

    rr_arb #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_arb (
        .req_i  (req),
        .ptr_i  (ptr_q),
        .pick_o (pick_s),
        .idx_o  (pick_idx_s)
    );

    assign addr_sel_s = req_addr[int'(pick_idx_s) * AW +: AW];

    // Sequencer FSM with its registered grant, address, data and error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            mem_addr_q <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_q      <= pick_s;
                        idx_q      <= pick_idx_s;
                        mem_addr_q <= addr_sel_s;
                        state_q    <= ST_READ;
                    end else begin
                        state_q    <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    cnt_q   <= '0;
                    state_q <= ST_DLY;
                end
                ST_DLY: begin
                    if (!ws) begin
                        rdata_q <= mem_rdata;
                        err_q   <= 1'b0;
                        state_q <= ST_DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q   <= cnt_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    ptr_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + PW'(1);
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
                // Anything not one-hot recovers to a clean idle.
                default: begin
                    gnt_q   <= '0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign state    = state_q;
    assign gnt      = gnt_q;
    assign mem_addr = mem_addr_q;
    assign rdata    = rdata_q;
    assign err      = err_q;
    assign mem_rd   = state_q[READ_BIT];
    assign done     = state_q[DONE_BIT] ? gnt_q : '0;

endmodule

// File: tb/tb_rd_seq_ctrl.sv
// Directed bench for rd_seq_ctrl with a transaction-timing reference model
// checked every cycle, plus literal expectations per scenario.
module tb_rd_seq_ctrl;

    localparam int NREQ = 2;
    localparam int AW   = 8;
    localparam int DW   = 8;
    localparam int TMO  = 15;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              err;
    logic [DW-1:0]     rdata;
    logic              mem_rd;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_rdata;
    logic              ws;
    logic [3:0]        state;

    int checks   = 0;
    int failures = 0;

    rd_seq_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW), .TMO(TMO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_addr  (req_addr),
        .gnt       (gnt),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_rd    (mem_rd),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .ws        (ws),
        .state     (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Reference: a transaction is granted at cycle m_start, strobes in that
    // cycle, evaluates ws from the second following edge on, and finishes
    // one cycle after its done cycle.
    int              m_cyc, m_start, m_done_at, m_waits, m_g, m_ptr;
    bit              m_busy;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_rdata;
    logic            m_err;

    function automatic int pick_w(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc <= 0; m_start <= -100; m_done_at <= -1; m_waits <= 0;
            m_g <= 0; m_ptr <= 0; m_busy <= 1'b0;
            m_addr <= '0; m_rdata <= '0; m_err <= 1'b0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (!m_busy) begin
                if (req != '0) begin
                    m_busy    <= 1'b1;
                    m_start   <= m_cyc + 1;
                    m_g       <= pick_w(req, m_ptr);
                    m_addr    <= req_addr[pick_w(req, m_ptr) * AW +: AW];
                    m_done_at <= -1;
                    m_waits   <= 0;
                end
            end else if (m_cyc + 1 - m_start == 1) begin
            end else if (m_done_at < 0) begin
                if (!ws) begin
                    m_rdata <= mem_rdata; m_err <= 1'b0; m_done_at <= m_cyc + 1;
                end else if (m_waits == TMO - 1) begin
                    m_rdata <= '0; m_err <= 1'b1; m_done_at <= m_cyc + 1;
                end else begin
                    m_waits <= m_waits + 1;
                end
            end else begin
                m_busy <= 1'b0;
                m_ptr  <= (m_g + 1) % NREQ;
            end
        end
    end

    // Per-cycle comparison against the reference.
    always @(posedge clk) begin
        logic [NREQ-1:0] eg;
        logic [3:0]      es;
        #1;
        if (!rst) begin
            eg = m_busy ? (NREQ'(1) << m_g) : '0;
            if (!m_busy)                 es = 4'b0001;
            else if (m_cyc == m_start)   es = 4'b0010;
            else if (m_cyc == m_done_at) es = 4'b1000;
            else                         es = 4'b0100;
            check("m_gnt", gnt, eg);
            check("m_mem_rd", mem_rd, m_busy && (m_cyc == m_start));
            check("m_done", done, (m_busy && m_cyc == m_done_at) ? eg : '0);
            check("m_mem_addr", mem_addr, m_addr);
            check("m_rdata", rdata, m_rdata);
            check("m_err", err, m_err);
            check("m_state", state, es);
        end
    end

    task automatic txn(input logic [1:0] r, input int waits, input logic [7:0] data,
                       input logic [1:0] exp_gnt, input logic [7:0] exp_addr, input int exp_lat,
                       input logic [7:0] exp_rdata, input logic exp_err, input int exp_dly);
        int c, nrd, ndly;
        bit got;
        logic [1:0] dval;
        logic [7:0] rd_addr;
        logic [NREQ*AW-1:0] saved;
        saved = req_addr;
        c = 0; nrd = 0; ndly = 0; got = 1'b0; dval = '0; rd_addr = '0;
        @(negedge clk);
        req = r; mem_rdata = data; ws = 1'b1;
        while (!got && c < 60) begin
            @(posedge clk); #1;
            c++;
            if (mem_rd) begin nrd++; rd_addr = mem_addr; end
            if (state == 4'b0100) ndly++;
            if (done != '0) begin got = 1'b1; dval = done; end
            if (!got) begin
                @(negedge clk);
                if (c == 1) begin req = '0; req_addr = ~saved; end
                ws = ((c - 2) < waits) ? 1'b1 : 1'b0;
            end
        end
        check("txn_done_seen", got, 1'b1);
        check("txn_latency", c, exp_lat);
        check("txn_done_val", dval, exp_gnt);
        check("txn_rdata", rdata, exp_rdata);
        check("txn_err", err, exp_err);
        check("txn_rd_count", nrd, 1);
        check("txn_rd_addr", rd_addr, exp_addr);
        check("txn_dly_cycles", ndly, exp_dly);
        @(negedge clk);
        ws = 1'b0;
        req_addr = saved;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_c[4];
        logic [1:0] exp_v[4];
        int dc[4];
        logic [1:0] dv[4];
        int nd;
        bit bad;
        exp_c = '{3, 7, 11, 15};
        exp_v = '{2'b01, 2'b10, 2'b01, 2'b10};

        rst = 1'b1; req = '0; req_addr = {8'h77, 8'h3C}; ws = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_state", state, 4'b0001);
        check("rst_gnt", gnt, 2'b00);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_done", done, 2'b00);
        check("rst_rdata", rdata, 8'h00);
        check("rst_err", err, 1'b0);
        check("rst_mem_addr", mem_addr, 8'h00);
        rst = 1'b0;

        txn(2'b01, 0,  8'hA5, 2'b01, 8'h3C, 3,  8'hA5, 1'b0, 1);
        txn(2'b01, 3,  8'h5A, 2'b01, 8'h3C, 6,  8'h5A, 1'b0, 4);
        txn(2'b01, 99, 8'hC3, 2'b01, 8'h3C, 17, 8'h00, 1'b1, 15);
        txn(2'b01, 14, 8'h3E, 2'b01, 8'h3C, 17, 8'h3E, 1'b0, 15);
        txn(2'b01, 0,  8'h11, 2'b01, 8'h3C, 3,  8'h11, 1'b0, 1);
        // Pointer now at 1: requester 1 alone.
        txn(2'b10, 0,  8'h22, 2'b10, 8'h77, 3,  8'h22, 1'b0, 1);

        // Contention with both requesters held.
        @(negedge clk);
        req = 2'b11; ws = 1'b0; mem_rdata = 8'h66; nd = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (done != '0 && nd < 4) begin dc[nd] = c; dv[nd] = done; nd++; end
            if (c == 15) begin @(negedge clk); req = '0; end
        end
        check("cont_count", nd, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < nd) begin
                check("cont_cycle", dc[i], exp_c[i]);
                check("cont_gnt", dv[i], exp_v[i]);
            end
        end
        check("cont_rdata", rdata, 8'h66);

        // Pointer now at 0: requester 1 alone.
        txn(2'b10, 0, 8'h33, 2'b10, 8'h77, 3, 8'h33, 1'b0, 1);

        // Reset while waiting in DLY.
        @(negedge clk);
        req = 2'b01; ws = 1'b1;
        @(negedge clk);
        req = '0;
        repeat (2) @(negedge clk);
        check("pre_rst_state", state, 4'b0100);
        rst = 1'b1;
        #1;
        check("mid_rst_state", state, 4'b0001);
        check("mid_rst_gnt", gnt, 2'b00);
        check("mid_rst_mem_rd", mem_rd, 1'b0);
        check("mid_rst_done", done, 2'b00);
        bad = 1'b0;
        repeat (2) begin @(posedge clk); #1; if (done != '0) bad = 1'b1; end
        @(negedge clk);
        rst = 1'b0; ws = 1'b0;
        repeat (3) begin @(posedge clk); #1; if (done != '0) bad = 1'b1; end
        check("mid_rst_no_done", bad, 1'b0);

        // Request dropped during READ, then nothing further granted.
        txn(2'b01, 0, 8'h44, 2'b01, 8'h3C, 3, 8'h44, 1'b0, 1);
        bad = 1'b0;
        repeat (10) begin @(posedge clk); #1; if (gnt != '0 || mem_rd) bad = 1'b1; end
        check("idle_after_drop", bad, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rd_seq_ctrl.md
Name: rd_seq_ctrl

Overview:
- Registered one-hot read sequencer: IDLE -> READ -> DLY -> DONE.
- Shares a single wait-stated memory read port between NREQ requesters using round-robin arbitration.
- Sits between requester blocks and the memory port: issues a one-cycle read strobe, waits out `ws`, captures the data, and returns a per-requester done pulse.
- Aborts with an error if the wait state exceeds a timeout.

Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 8, address width
- DW, 8, data width
- TMO, 15, number of consecutive `ws` cycles in DLY that triggers an abort (TMO >= 1)

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester read request, level
- req_addr  input  NREQ*AW  flattened request addresses; requester i uses bits [i*AW +: AW]
- gnt  output  NREQ  one-hot grant, registered
- done  output  NREQ  one-cycle completion pulse to the granted requester
- err  output  1  timeout flag, valid while any `done` bit is high
- rdata  output  DW  captured read data, registered
- mem_rd  output  1  memory read strobe
- mem_addr  output  AW  registered memory address
- mem_rdata  input  DW  memory read data, valid in a DLY cycle with ws=0
- ws  input  1  memory wait state, high = data not ready
- state  output  4  one-hot state for debug: IDLE=0001, READ=0010, DLY=0100, DONE=1000

Behaviour:
- Reset (async, immediate):
  - state=IDLE; gnt=0, mem_addr=0, rdata=0, err=0, wait counter=0, round-robin pointer=0.
  - Decoded outputs follow: mem_rd=0, done=0.
  - Reset mid-transaction abandons the read with no done pulse.
- Decoded outputs, taken from registered state only:
  - mem_rd = state[READ].
  - done = gnt when state[DONE], else 0.
- IDLE:
  - No req: remain in IDLE.
  - Any req: at the clock edge, grant the first set req bit at or after the pointer, wrapping; load gnt and mem_addr from that requester's address; go to READ.
- READ (exactly 1 cycle): mem_rd=1; clear wait counter; go to DLY.
- DLY:
  - ws=0: rdata<=mem_rdata, err<=0, go to DONE.
  - ws=1 and cnt<TMO-1: cnt<=cnt+1, stay in DLY.
  - ws=1 and cnt==TMO-1: err<=1, rdata<=0, go to DONE.
  - Counter width is clog2(TMO)+1 and it never wraps.
- DONE (exactly 1 cycle):
  - done pulse to the granted requester.
  - Pointer <= granted index+1 mod NREQ; gnt<=0; go to IDLE.
  - err and rdata hold until the next DONE or reset.
- Latency: req sampled at edge E0 -> mem_rd high in cycle E0+1 -> done high in cycle E0+3 when there are no waits. Each wait cycle adds 1 cycle.
- Minimum issue interval per transaction is 4 cycles; there is no back-to-back bypass.
- Requests during a transaction:
  - Changes to req or req_addr after the grant are ignored; the transaction always completes.
  - A dropped request still gets its done pulse.
- Simultaneous requests: exactly one grant per transaction. Continuously asserting requesters are served in rotating order, so none starves.
- Illegal state (not one-hot, e.g. after an upset): the next state is IDLE and gnt clears.

Decomposition:
- Shared include file holds:
  - state encodings and one-hot bit indices (IDLE=0, READ=1, DLY=2, DONE=3);
  - width helper for the wait counter.
- One sub-module: rr_arb.
  - Combinational round-robin picker.
  - Inputs: req, pointer. Outputs: one-hot pick, binary index.
  - Instantiated once; the FSM registers its result in IDLE.

Test Plan:
- Single request, no waits: req=01, addr0=0x3C, ws=0, mem_rdata=0xA5.
  - Expect mem_rd=1 for one cycle with mem_addr=0x3C.
  - Expect done=01, rdata=0xA5, err=0 three cycles after the sampling edge.
- Wait states: ws high for 3 DLY cycles, then low with mem_rdata=0x5A.
  - Expect done delayed by exactly 3 cycles, rdata=0x5A, err=0.
- Timeout: TMO=15, ws held high.
  - Expect DLY for 15 cycles, then DONE with err=1, rdata=0x00 and a done pulse.
  - Next transaction with ws=0 clears err.
- Contention: req=11 held continuously.
  - Expect grants alternating 01,10,01,10 across four transactions with a 4-cycle spacing.
  - Then req=10 only: requester 1 is granted even when the pointer is at 1 or 0.
- Reset mid-operation: assert rst during a DLY cycle.
  - Expect state=0001, gnt=0, mem_rd=0, done=0 immediately, with no done pulse.
  - After release, a new req=01 completes normally.
- Request dropped after grant: req=01 deasserted during READ.
  - Expect the transaction still completes with a done=01 pulse.
  - Expect no further grant afterwards.
